// File: rtl/nou_out_interface_unit.sv
// Router-to-NOU egress: credit-fed flit FIFO presented over a valid/ready handshake.
// Every dequeued flit returns one registered yummy credit to the router.
module nou_out_interface_unit #(
   parameter int unsigned DAT_WIDTH  = 8,
   parameter int unsigned TID_WIDTH  = 4,
   parameter int unsigned TYPE_WIDTH = 2,
   parameter int unsigned WIDTH      = TID_WIDTH + TYPE_WIDTH + DAT_WIDTH,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      router_niou_data,
   input  logic                  router_niou_valid,
   output logic                  niou_router_yummy,
   output logic [TID_WIDTH-1:0]  niou_nou_tid,
   output logic [TYPE_WIDTH-1:0] niou_nou_type,
   output logic [DAT_WIDTH-1:0]  niou_nou_data,
   output logic                  niou_nou_valid,
   input  logic                  nou_niou_ready,
   output logic                  niou_ovf_err
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full_c;
   logic             push_c;
   logic             pop_c;
   logic [WIDTH-1:0] head_c;

   // Pointers wrap at DEPTH-1 so non power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Push is judged on the pre-pop count: a flit arriving while full is dropped.
   always_comb begin
      full_c = (count == CNT_W'(DEPTH));
      push_c = router_niou_valid && !full_c;
      pop_c  = niou_nou_valid && nou_niou_ready;
      head_c = mem[rd_ptr];
   end

   assign niou_nou_valid = (count != '0);
   assign niou_nou_tid   = head_c[WIDTH-1 -: TID_WIDTH];
   assign niou_nou_type  = head_c[DAT_WIDTH +: TYPE_WIDTH];
   assign niou_nou_data  = head_c[DAT_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         niou_router_yummy <= 1'b0;
         niou_ovf_err      <= 1'b0;
      end else begin
         if (push_c) begin
            mem[wr_ptr] <= router_niou_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop_c) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push_c, pop_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         niou_router_yummy <= pop_c;
         if (router_niou_valid && full_c) begin
            niou_ovf_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nou_out_interface_unit.sv
// Bench for nou_out_interface_unit: directed scenarios on a DEPTH=2 instance and a
// credit-driven random run on a DEPTH=3 instance, both checked against a queue model.
module tb_nou_out_interface_unit;

   localparam int unsigned TW = 4;
   localparam int unsigned YW = 2;
   localparam int unsigned DW = 8;
   localparam int unsigned W  = TW + YW + DW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          v2, r2, y2, ov2, ovf2;
   logic [W-1:0]  d2;
   logic [TW-1:0] tid2;
   logic [YW-1:0] ty2;
   logic [DW-1:0] da2;
   logic          v3, r3, y3, ov3, ovf3;
   logic [W-1:0]  d3;
   logic [TW-1:0] tid3;
   logic [YW-1:0] ty3;
   logic [DW-1:0] da3;

   nou_out_interface_unit #(.DAT_WIDTH(DW), .TID_WIDTH(TW), .TYPE_WIDTH(YW), .WIDTH(W), .DEPTH(2)) dut2 (
      .clk(clk), .rst(rst),
      .router_niou_data(d2), .router_niou_valid(v2), .niou_router_yummy(y2),
      .niou_nou_tid(tid2), .niou_nou_type(ty2), .niou_nou_data(da2),
      .niou_nou_valid(ov2), .nou_niou_ready(r2), .niou_ovf_err(ovf2)
   );

   nou_out_interface_unit #(.DAT_WIDTH(DW), .TID_WIDTH(TW), .TYPE_WIDTH(YW), .WIDTH(W), .DEPTH(3)) dut3 (
      .clk(clk), .rst(rst),
      .router_niou_data(d3), .router_niou_valid(v3), .niou_router_yummy(y3),
      .niou_nou_tid(tid3), .niou_nou_type(ty3), .niou_nou_data(da3),
      .niou_nou_valid(ov3), .nou_niou_ready(r3), .niou_ovf_err(ovf3)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: FIFO contents, pending credit, sticky overflow.
   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   bit ya, yb, oa, ob;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] flit(input int t, input int y, input int d);
      return {TW'(t), YW'(y), DW'(d)};
   endfunction

   // One cycle: drive inputs, compare outputs to the model, advance the model, clock.
   task automatic step(input int k, input bit v, input logic [W-1:0] d, input bit r);
      logic [W-1:0] q[$];
      logic [W-1:0] h;
      bit ey, eo, pop, push;
      int dep, cnt;
      logic ov, yy, ovf;
      logic [TW-1:0] tid;
      logic [YW-1:0] ty;
      logic [DW-1:0] da;
      if (k == 0) begin
         v2 = v; d2 = d; r2 = r; q = qa; ey = ya; eo = oa; dep = 2;
         ov = ov2; yy = y2; ovf = ovf2; tid = tid2; ty = ty2; da = da2; cnt = int'(dut2.count);
      end else begin
         v3 = v; d3 = d; r3 = r; q = qb; ey = yb; eo = ob; dep = 3;
         ov = ov3; yy = y3; ovf = ovf3; tid = tid3; ty = ty3; da = da3; cnt = int'(dut3.count);
      end
      chk($sformatf("valid[%0d]", k), 32'(ov), 32'(q.size() != 0));
      chk($sformatf("yummy[%0d]", k), 32'(yy), 32'(ey));
      chk($sformatf("ovf[%0d]", k), 32'(ovf), 32'(eo));
      chk($sformatf("count[%0d]", k), 32'(cnt), 32'(q.size()));
      if (q.size() != 0) begin
         h = q[0];
         chk($sformatf("tid[%0d]", k), 32'(tid), 32'(h[W-1 -: TW]));
         chk($sformatf("type[%0d]", k), 32'(ty), 32'(h[DW +: YW]));
         chk($sformatf("data[%0d]", k), 32'(da), 32'(h[DW-1:0]));
      end
      push = v && (q.size() < dep);
      pop  = (q.size() != 0) && r;
      if (v && q.size() >= dep) eo = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      ey = pop;
      if (k == 0) begin qa = q; ya = ey; oa = eo; end
      else begin qb = q; yb = ey; ob = eo; end
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 32'(ov2), 32'd0);
      chk({tag, "_yummy"}, 32'(y2), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf2), 32'd0);
      chk({tag, "_fields"}, 32'({tid2, ty2, da2}), 32'd0);
      chk({tag, "_count"}, 32'(dut2.count), 32'd0);
   endtask

   initial begin
      logic [W-1:0] fa, fb, fc, fd;
      int credits;
      rst = 1'b0;
      v2 = 0; r2 = 0; d2 = '0; v3 = 0; r3 = 0; d3 = '0;
      qa.delete(); qb.delete(); ya = 0; yb = 0; oa = 0; ob = 0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      chk("reset_valid3", 32'(ov3), 32'd0);
      rst = 1'b1;

      // Single flit split into fields, credit one cycle after the pop
      step(0, 1, flit(3, 1, 8'hA5), 1);
      chk("t1_valid", 32'(ov2), 32'd1);
      chk("t1_tid", 32'(tid2), 32'd3);
      chk("t1_type", 32'(ty2), 32'd1);
      chk("t1_data", 32'(da2), 32'hA5);
      step(0, 0, '0, 1);
      chk("t1_yummy", 32'(y2), 32'd1);
      step(0, 0, '0, 0);
      chk("t1_yummy_end", 32'(y2), 32'd0);

      // Back-pressure holds head stable, then two back-to-back pops
      fa = flit(1, 2, 8'h11);
      fb = flit(2, 3, 8'h22);
      step(0, 1, fa, 0);
      step(0, 1, fb, 0);
      step(0, 0, '0, 0);
      chk("t2_headA", 32'(da2), 32'h11);
      chk("t2_noyummy", 32'(y2), 32'd0);
      step(0, 0, '0, 1);
      chk("t2_y1", 32'(y2), 32'd1);
      chk("t2_headB", 32'(da2), 32'h22);
      step(0, 0, '0, 1);
      chk("t2_y2", 32'(y2), 32'd1);
      chk("t2_empty", 32'(ov2), 32'd0);
      step(0, 0, '0, 0);
      chk("t2_y3", 32'(y2), 32'd0);

      // Overflow while full, then while full with a simultaneous pop
      fc = flit(4, 0, 8'h33);
      fd = flit(5, 1, 8'h44);
      step(0, 1, fa, 0);
      step(0, 1, fb, 0);
      step(0, 1, fc, 0);
      chk("t3_ovf", 32'(ovf2), 32'd1);
      chk("t3_cnt2", 32'(dut2.count), 32'd2);
      chk("t3_noyummy", 32'(y2), 32'd0);
      step(0, 0, '0, 0);
      chk("t3_sticky", 32'(ovf2), 32'd1);
      step(0, 1, fd, 1);
      chk("t3_cnt1", 32'(dut2.count), 32'd1);
      chk("t3_headB", 32'(da2), 32'h22);
      step(0, 0, '0, 1);
      step(0, 0, '0, 0);
      chk("t3_sticky2", 32'(ovf2), 32'd1);

      // Streaming with ready held high
      for (int i = 0; i < 20; i++) begin
         step(0, 1, W'($urandom), 1);
         chk("t4_cnt_le1", 32'(dut2.count <= 1), 32'd1);
         if (i > 0) chk("t4_yummy", 32'(y2), 32'd1);
      end
      step(0, 0, '0, 1);
      step(0, 0, '0, 0);

      // Reset with two entries held discards them without credits
      step(0, 1, fc, 0);
      step(0, 1, fd, 0);
      rst = 1'b0;
      v2 = 1; d2 = fa;
      @(posedge clk);
      #1;
      check_zero("t6");
      qa.delete(); qb.delete(); ya = 0; yb = 0; oa = 0; ob = 0;
      rst = 1'b1;
      step(0, 1, flit(7, 2, 8'h5C), 1);
      chk("t6_after_data", 32'(da2), 32'h5C);
      step(0, 0, '0, 1);
      step(0, 0, '0, 0);
      v2 = 0; r2 = 0;

      // Random valid/ready on DEPTH=3 with a credit-respecting upstream
      credits = 3;
      for (int i = 0; i < 10000; i++) begin
         bit v;
         v = (credits > 0) && ($urandom_range(0, 3) != 0);
         if (v) credits--;
         step(1, v, W'($urandom), bit'($urandom_range(0, 1)));
         if (yb) credits++;
      end
      for (int i = 0; i < 6; i++) begin
         step(1, 0, '0, 1);
         if (yb) credits++;
      end
      chk("t5_drained", 32'(ov3), 32'd0);
      chk("t5_ovf", 32'(ovf3), 32'd0);
      chk("t5_credits", 32'(credits), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
